// File: rtl/ram_ctrl_pkg.sv
// Shared types for the single-port RAM request controller.
// State encoding and the Moore decode of the RAM strobes live here.
package ram_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

    typedef struct packed {
        logic cs;
        logic we;
        logic oe;
    } strobes_t;

    // Both read states hold cs/oe so the RAM keeps its registered output on the bus.
    function automatic strobes_t decode_strobes(input state_t s);
        strobes_t r;
        r = '0;
        case (s)
            ST_WR:      r = '{cs: 1'b1, we: 1'b1, oe: 1'b0};
            ST_RD_ADDR: r = '{cs: 1'b1, we: 1'b0, oe: 1'b1};
            ST_RD_DATA: r = '{cs: 1'b1, we: 1'b0, oe: 1'b1};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_sp_ctrl.sv
// Valid/ready front end for a single-port synchronous RAM with a shared data bus.
// Writes take one strobe cycle; reads take address, data and bus-turnaround cycles.
module ram_sp_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    accept;
    strobes_t                strobes;

    // A stalled response blocks new work; consuming it frees the slot on the same edge.
    assign req_ready = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR:      state_d = ST_IDLE;
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                rsp_rdata_d = ram_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_TURN;
            end
            ST_TURN:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign strobes     = decode_strobes(state_q);
    assign ram_cs      = strobes.cs;
    assign ram_we      = strobes.we;
    assign ram_oe      = strobes.oe;
    assign ram_address = addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

    // Only the write state drives the shared bus; reset forces IDLE, so it is released then too.
    assign ram_data = (state_q == ST_WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl paired with a behavioural single-port synchronous RAM.
// Stimulus pushes expected read data into a queue; a monitor pops and compares.
module tb_ram_sp_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_address;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;

    always #5 clk = ~clk;

    ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_oe     (ram_oe)
    );

    // Behavioural model of the single-port synchronous RAM with registered read data.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ram_dout;

    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
        if (ram_cs && !ram_we && ram_oe) ram_dout <= ram_mem[ram_address];
    end

    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout : {DW{1'bz}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model: plain memory array plus in-order queue of expected read data.
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wr_exp_data;
    logic [AW-1:0] wr_exp_addr;
    logic [AW-1:0] slots [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h7F, 8'h80, 8'hC3, 8'hFF};

    int ready_mode  = 0;
    int stall_seen  = 0;
    int release_cyc = -1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Mode 0: always ready; mode 1: random back-pressure; mode 2: hold off 5 valid cycles.
    task automatic drive_rsp_ready();
        case (ready_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (rsp_valid) stall_seen++;
                if (stall_seen > 5) begin
                    rsp_ready   = 1'b1;
                    release_cyc = cyc;
                    ready_mode  = 0;
                end else begin
                    rsp_ready = 1'b0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 output int acc_cyc);
        bit done = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = addr;
            req_wdata = data;
            drive_rsp_ready();
            #1;
            if (req_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                if (we) begin
                    ref_mem[addr] = data;
                    wr_exp_data   = data;
                    wr_exp_addr   = addr;
                end else begin
                    exp_q.push_back(ref_mem[addr]);
                end
            end
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            drive_rsp_ready();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || rsp_valid); i++) idleCycles(1);
        idleCycles(2);
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples 2 time units after the falling edge, judging the upcoming rising edge.
    int   busy, oe_left, rd_acc_cyc;
    logic we_next, prev_valid, prev_stall;
    logic [DW-1:0] prev_rdata;

    initial begin
        busy = 0; oe_left = 0; rd_acc_cyc = 0;
        we_next = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0; prev_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                busy = 0; oe_left = 0; we_next = 1'b0;
                prev_valid = 1'b0; prev_stall = 1'b0;
                continue;
            end
            checkOutput("strobes_cs_we_oe", 32'({ram_cs, ram_we, ram_oe}),
                        32'({we_next || (oe_left > 0), we_next, oe_left > 0}));
            if (we_next) begin
                checkOutput("wr_bus_data", 32'(ram_data), 32'(wr_exp_data));
                checkOutput("wr_address", 32'(ram_address), 32'(wr_exp_addr));
            end
            if (busy > 0) begin
                checkOutput("req_ready_while_busy", 32'(req_ready), 32'd0);
                busy--;
            end
            if (oe_left > 0) oe_left--;
            we_next = 1'b0;
            if (rsp_valid && !prev_valid) checkOutput("rd_latency", 32'(cyc - rd_acc_cyc), 32'd3);
            if (prev_stall) begin
                checkOutput("stall_valid_held", 32'(rsp_valid), 32'd1);
                checkOutput("stall_data_stable", 32'(rsp_rdata), 32'(prev_rdata));
            end
            if (rsp_valid && !rsp_ready) checkOutput("no_accept_while_stalled", 32'(req_ready), 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) checkOutput("unexpected_rsp", 32'd1, 32'd0);
                else checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    busy    = 1;
                    we_next = 1'b1;
                end else begin
                    busy       = 3;
                    oe_left    = 2;
                    rd_acc_cyc = cyc;
                end
            end
            prev_valid = rsp_valid;
            prev_stall = rsp_valid && !rsp_ready;
            prev_rdata = rsp_rdata;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("reset_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
        checkOutput("reset_address", 32'(ram_address), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(2);

        ready_mode = 0;
        applyStimulus(1'b1, 8'h10, 8'hAA, acc);
        applyStimulus(1'b0, 8'h10, 8'h00, acc);
        drain();

        applyStimulus(1'b1, 8'h20, 8'h55, acc);
        applyStimulus(1'b1, 8'hFF, 8'h3C, acc);
        applyStimulus(1'b0, 8'hFF, 8'h00, acc);
        applyStimulus(1'b0, 8'h20, 8'h00, acc);
        drain();

        ready_mode = 2;
        stall_seen = 0;
        applyStimulus(1'b0, 8'h10, 8'h00, acc);
        applyStimulus(1'b1, 8'h30, 8'h77, acc);
        checkOutput("write_accepted_on_release", 32'(acc), 32'(release_cyc));
        drain();

        ready_mode = 0;
        applyStimulus(1'b0, 8'h10, 8'h00, acc);
        @(negedge clk);
        @(negedge clk);
        #3;
        checkOutput("rd_data_cs_before_reset", 32'(ram_cs), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_cs", 32'(ram_cs), 32'd0);
        checkOutput("async_reset_oe", 32'(ram_oe), 32'd0);
        checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("async_reset_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        req_valid = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;
        idleCycles(1);
        applyStimulus(1'b0, 8'h10, 8'h00, acc);
        drain();

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, slots[i], DW'($urandom), acc);
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'(i % 2), slots[$urandom_range(0, 7)], DW'($urandom), acc);
        end
        for (int i = 0; i < 250; i++) begin
            applyStimulus(1'($urandom), slots[$urandom_range(0, 7)], DW'($urandom), acc);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_sp_ctrl.md
Name: ram_sp_ctrl

Overview:
- Request-side controller sitting directly upstream of the single-port synchronous RAM (ram_sp_sr_sw).
- Converts a valid/ready request stream (read or write) into the RAM's cs/we/oe/address strobes and its shared bidirectional data bus.
- Returns read data on a valid/ready response channel.
- Owns bus turnaround so controller and RAM never drive the data bus together.

Parameters:
- DATA_WIDTH, 8, width of the RAM data bus and of request/response data.
- ADDR_WIDTH, 8, width of the RAM address; RAM depth is 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DATA_WIDTH  read data.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_data  inout  DATA_WIDTH  to RAM shared data bus.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE, req_ready 0 while rst high, rsp_valid 0, rsp_rdata 0, ram_cs/ram_we/ram_oe 0, ram_address 0, ram_data released (all Z). Reset asserted mid-operation aborts immediately (asynchronously), with no response and no write completion guaranteed.
- States: IDLE, WR, RD_ADDR, RD_DATA, TURN.
- RAM strobes are Moore outputs decoded from the state register.
- ram_address is driven from the latched request register.
- IDLE:
  - req_ready = !rsp_valid || rsp_ready.
  - On req_valid && req_ready: latch addr/we/wdata, then go to WR if req_we, else RD_ADDR.
  - All strobes 0, bus Z.
- WR (1 cycle):
  - ram_cs=1, ram_we=1, ram_oe=0.
  - Controller drives ram_data = latched wdata; RAM writes at the closing edge.
  - Next state IDLE. No response is generated for writes.
- RD_ADDR (1 cycle):
  - ram_cs=1, ram_we=0, ram_oe=1, bus Z.
  - RAM samples the address at the closing edge. Next state RD_DATA.
- RD_DATA (1 cycle):
  - Same strobes as RD_ADDR.
  - At the closing edge: rsp_rdata <= ram_data, rsp_valid <= 1. Next state TURN.
- TURN (1 cycle): all strobes 0, bus Z (RAM releases). Next state IDLE.
- Latency and throughput:
  - Write: accept-to-RAM-write is 1 cycle; one write per 2 cycles.
  - Read: rsp_valid rises 3 cycles after the accept edge; one read per 4 cycles.
- Response channel:
  - rsp_valid holds, and rsp_rdata stays stable, until rsp_valid && rsp_ready, then clears on that edge.
  - A new request may be accepted on the same edge the pending response is consumed.
  - While a response is stalled, no new request (read or write) is accepted.
- Bus rule: ram_data is driven by the controller only in WR; it is Z in every other state and during reset.
- Address wrap: none internal; addresses are passed through verbatim, so 0xFF is valid with ADDR_WIDTH=8.
- req_* inputs are ignored when req_ready=0; no X-propagation into state from an ignored request.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state encoding localparams (IDLE=0, WR=1, RD_ADDR=2, RD_DATA=3, TURN=4; 3-bit);
  - DATA_WIDTH/ADDR_WIDTH defaults.
- No sub-module: the tristate driver is a single continuous assign inside ram_sp_ctrl.
- Bench pairs ram_sp_ctrl with the existing ram_sp_sr_sw instance.

Test Plan:
- Write 0x10<-0xAA, then read 0x10:
  - ram_cs=1, ram_we=1 for exactly one cycle with ram_data=0xAA;
  - rsp_valid rises 3 cycles after read accept with rsp_rdata=0xAA.
- Write 0x20<-0x55, write 0xFF<-0x3C, read 0xFF, read 0x20:
  - responses are 0x3C then 0x55 in order;
  - req_ready pattern is 1,0 per write and 1,0,0,0 per read.
- Read 0x10 with rsp_ready=0 for 5 cycles:
  - rsp_valid stays 1 and rsp_rdata stays 0xAA;
  - req_ready=0 throughout;
  - a write request held valid is accepted on the cycle rsp_ready rises.
- Assert rst during RD_DATA:
  - ram_cs/ram_oe/rsp_valid drop to 0 the same timestep without a clock edge;
  - after release, state is IDLE and a read of 0x10 returns 0xAA.
- Contention check across all scenarios: no X or strength conflict on ram_data in any cycle; ram_data is Z in TURN and IDLE.
- req_valid=1 held continuously with alternating we:
  - each accept occurs only in IDLE;
  - no request is lost or duplicated (scoreboard against an 8-entry reference model).
